// File: rtl/send_queue_arbiter.sv
// send_queue_arbiter: write side of the 512-entry UART transmit ring.
// Shares the ring between a byte-wide CPU producer and a debug producer that
// emits 32-bit words as atomic 4-byte bursts (MSB first). Free space is
// derived from the output manager's head pointer; one slot always stays empty.
module send_queue_arbiter (
   input  logic        CLK,
   input  logic        INITIALIZE,
   input  logic        cpu_valid,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ready,
   input  logic        dbg_valid,
   input  logic [31:0] dbg_word,
   output logic        dbg_ready,
   input  logic [8:0]  queue_s,
   output logic [7:0]  send_queue [0:511],
   output logic [8:0]  queue_t,
   output logic [8:0]  queue_free
);

   typedef enum logic [1:0] {StIdle, StDbg1, StDbg2, StDbg3} state_e;

   state_e      state_q, state_d;
   logic        last_q, last_d;      // 0: CPU served last, 1: debug served last
   logic [23:0] word_q, word_d;      // remaining bytes of the debug word in flight
   logic        cpu_cand, dbg_cand;
   logic        wr_en;
   logic [7:0]  wr_data;

   // Free slots; 9-bit wrap gives the mod-512 result directly.
   assign queue_free = queue_s - queue_t - 9'd1;

   // Arbitration, ready generation and write-port selection.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      word_d    = word_q;
      wr_en     = 1'b0;
      wr_data   = 8'h00;
      cpu_ready = 1'b0;
      dbg_ready = 1'b0;
      // With both requesting, the one not served last is the candidate.
      cpu_cand  = cpu_valid && (!dbg_valid || last_q);
      dbg_cand  = dbg_valid && (!cpu_valid || !last_q);
      unique case (state_q)
         StIdle: begin
            // A candidate short of space holds its turn rather than yielding.
            if (!INITIALIZE) begin
               cpu_ready = cpu_cand && (queue_free != 9'd0);
               dbg_ready = dbg_cand && (queue_free >= 9'd4);
            end
            if (cpu_valid && cpu_ready) begin
               wr_en   = 1'b1;
               wr_data = cpu_data;
               last_d  = 1'b0;
            end else if (dbg_valid && dbg_ready) begin
               wr_en   = 1'b1;
               wr_data = dbg_word[31:24];
               word_d  = dbg_word[23:0];
               last_d  = 1'b1;
               state_d = StDbg1;
            end
         end
         // Four slots were reserved at acceptance, so no space check here.
         StDbg1: begin
            wr_en   = 1'b1;
            wr_data = word_q[23:16];
            state_d = StDbg2;
         end
         StDbg2: begin
            wr_en   = 1'b1;
            wr_data = word_q[15:8];
            state_d = StDbg3;
         end
         StDbg3: begin
            wr_en   = 1'b1;
            wr_data = word_q[7:0];
            state_d = StIdle;
         end
      endcase
   end

   // Control state and tail pointer; reset is asynchronous and may hit mid-burst.
   always_ff @(posedge CLK or posedge INITIALIZE) begin
      if (INITIALIZE) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         word_q  <= 24'h000000;
         queue_t <= 9'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         word_q  <= word_d;
         if (wr_en) begin
            queue_t <= queue_t + 9'd1;
         end
      end
   end

   // Ring storage; contents survive reset, written on the same edge as the tail.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         send_queue[queue_t] <= wr_data;
      end
   end

endmodule

// File: tb/tb_send_queue_arbiter.sv
// Scoreboard bench for send_queue_arbiter: a byte-level ring model predicts
// readys, free space and the sequence of (slot, byte) writes.
module tb_send_queue_arbiter;

   logic        CLK = 1'b0;
   logic        INITIALIZE = 1'b1;
   logic        cpu_valid = 1'b0;
   logic [7:0]  cpu_data = 8'h00;
   logic        cpu_ready;
   logic        dbg_valid = 1'b0;
   logic [31:0] dbg_word = 32'h0;
   logic        dbg_ready;
   logic [8:0]  s = 9'd0;
   logic [7:0]  send_queue [0:511];
   logic [8:0]  queue_t;
   logic [8:0]  queue_free;

   send_queue_arbiter dut (
      .CLK        (CLK),
      .INITIALIZE (INITIALIZE),
      .cpu_valid  (cpu_valid),
      .cpu_data   (cpu_data),
      .cpu_ready  (cpu_ready),
      .dbg_valid  (dbg_valid),
      .dbg_word   (dbg_word),
      .dbg_ready  (dbg_ready),
      .queue_s    (s),
      .send_queue (send_queue),
      .queue_t    (queue_t),
      .queue_free (queue_free)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [8:0] slot;
      logic [7:0] data;
   } wr_t;

   wr_t sb [$];
   int  errors = 0;
   int  checks = 0;

   // Reference model: reserved tail, bytes of a burst still to land, fairness bit.
   logic       model_en = 1'b0;
   logic [8:0] m_tail = 9'd0;
   int         m_busy = 0;
   logic       m_last = 1'b1;
   logic [8:0] m_commit, m_free;
   logic       m_ccand, m_dcand, m_ecr, m_edr;
   wr_t        m_ent, mon_ent;
   logic [8:0] prev_t = 9'd0;
   logic [8:0] mon_delta;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: predict readys and free space, queue expected writes on acceptance.
   always @(negedge CLK) begin
      if (model_en) begin
         m_commit = m_tail - 9'(m_busy);
         m_free   = s - m_commit - 9'd1;
         check("queue_free", 32'(queue_free), 32'(m_free));
         m_ecr = 1'b0;
         m_edr = 1'b0;
         if (m_busy == 0) begin
            m_ccand = cpu_valid && (!dbg_valid || m_last);
            m_dcand = dbg_valid && (!cpu_valid || !m_last);
            m_ecr   = m_ccand && (int'(m_free) >= 1);
            m_edr   = m_dcand && (int'(m_free) >= 4);
         end
         check("cpu_ready", 32'(cpu_ready), 32'(m_ecr));
         check("dbg_ready", 32'(dbg_ready), 32'(m_edr));
         if (m_busy > 0) begin
            m_busy--;
         end else if (cpu_valid && m_ecr) begin
            m_ent.slot = m_tail;
            m_ent.data = cpu_data;
            sb.push_back(m_ent);
            m_tail = m_tail + 9'd1;
            m_last = 1'b0;
         end else if (dbg_valid && m_edr) begin
            for (int k = 0; k < 4; k++) begin
               m_ent.slot = m_tail + 9'(k);
               m_ent.data = dbg_word[31 - 8*k -: 8];
               sb.push_back(m_ent);
            end
            m_tail = m_tail + 9'd4;
            m_busy = 3;
            m_last = 1'b1;
         end
      end
   end

   // Monitor: every tail advance must be one expected byte in the expected slot.
   always @(negedge CLK) begin
      if (model_en) begin
         mon_delta = queue_t - prev_t;
         if (mon_delta != 9'd0) begin
            check("tail_step", 32'(mon_delta), 32'd1);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: slot %0d got %0h expected none",
                        prev_t, send_queue[prev_t]);
            end else begin
               mon_ent = sb.pop_front();
               check("write_slot", 32'(prev_t), 32'(mon_ent.slot));
               check("write_data", 32'(send_queue[mon_ent.slot]), 32'(mon_ent.data));
            end
         end
         prev_t = queue_t;
      end
   end

   task automatic cycle(input logic cv, input logic [7:0] cd, input logic dv,
                        input logic [31:0] dw, input logic [8:0] sn);
      @(posedge CLK);
      #1;
      cpu_valid = cv;
      cpu_data  = cd;
      dbg_valid = dv;
      dbg_word  = dw;
      s         = sn;
   endtask

   // Output-manager stand-in: drains only bytes that have actually landed.
   function automatic logic [8:0] drained();
      if (s != (m_tail - 9'(m_busy)) && $urandom_range(0, 2) == 0) return s + 9'd1;
      return s;
   endfunction

   task automatic model_restart();
      m_tail = 9'd0;
      m_busy = 0;
      m_last = 1'b1;
      prev_t = 9'd0;
      sb.delete();
      model_en = 1'b1;
   endtask

   task automatic do_reset();
      model_en  = 1'b0;
      INITIALIZE = 1'b1;
      cpu_valid = 1'b1;
      dbg_valid = 1'b1;
      s         = 9'd0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_queue_t", 32'(queue_t), 32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
      check("rst_queue_free", 32'(queue_free), 32'd511);
      INITIALIZE = 1'b0;
      cpu_valid  = 1'b0;
      dbg_valid  = 1'b0;
      model_restart();
   endtask

   initial begin
      // Single CPU byte.
      do_reset();
      cycle(1'b1, 8'h41, 1'b0, 32'h0, 9'd0);
      cycle(1'b0, 8'h00, 1'b0, 32'h0, 9'd0);
      #1;
      check("single_data", 32'(send_queue[0]), 32'h41);
      check("single_tail", 32'(queue_t), 32'd1);
      check("single_free", 32'(queue_free), 32'd510);

      // Contention from reset: CPU first, then alternating.
      do_reset();
      repeat (24) cycle(1'b1, 8'($urandom), 1'b1, $urandom, drained());
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 32'h0, s);

      // Full ring, then one freed slot, then debug reservation at free = 3.
      do_reset();
      repeat (515) cycle(1'b1, 8'($urandom), 1'b0, 32'h0, 9'd0);
      #1;
      check("full_free", 32'(queue_free), 32'd0);
      check("full_cpu_ready", 32'(cpu_ready), 32'd0);
      repeat (3) cycle(1'b1, 8'($urandom), 1'b0, 32'h0, 9'd1);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 32'hCAFEF00D, 9'd4);
      #1;
      check("resv_dbg_ready", 32'(dbg_ready), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 32'hCAFEF00D, 9'd5);
      repeat (6) cycle(1'b0, 8'h00, 1'b0, 32'h0, 9'd5);
      #1;
      check("resv_tail", 32'(queue_t), 32'd4);

      // Debug word straddling the wrap.
      do_reset();
      repeat (510) cycle(1'b1, 8'($urandom), 1'b0, 32'h0, 9'd0);
      cycle(1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 9'd4);
      repeat (6) cycle(1'b0, 8'h00, 1'b0, 32'h0, 9'd4);
      #1;
      check("wrap_tail", 32'(queue_t), 32'd2);
      check("wrap_510", 32'(send_queue[510]), 32'hDE);
      check("wrap_511", 32'(send_queue[511]), 32'hAD);
      check("wrap_0", 32'(send_queue[0]), 32'hBE);
      check("wrap_1", 32'(send_queue[1]), 32'hEF);

      // Asynchronous reset while in DBG2.
      cycle(1'b0, 8'h00, 1'b1, 32'h11223344, 9'd100);
      cycle(1'b0, 8'h00, 1'b0, 32'h0, 9'd100);
      cycle(1'b1, 8'h77, 1'b0, 32'h0, 9'd100);
      model_en = 1'b0;
      #1;
      INITIALIZE = 1'b1;
      #1;
      check("midrst_tail", 32'(queue_t), 32'd0);
      check("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
      @(posedge CLK);
      #1;
      INITIALIZE = 1'b0;
      cpu_valid  = 1'b0;
      s          = 9'd0;
      model_restart();
      cycle(1'b1, 8'h5A, 1'b0, 32'h0, 9'd0);
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 32'h0, 9'd0);
      #1;
      check("midrst_slot0", 32'(send_queue[0]), 32'h5A);
      check("midrst_tail_after", 32'(queue_t), 32'd1);

      // Randomized traffic with random draining.
      repeat (3000) begin
         cycle(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) == 0),
               $urandom, drained());
      end
      repeat (8) cycle(1'b0, 8'h00, 1'b0, 32'h0, s);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
